ball_motion: RTL and testbench

- Position generator for the bouncing-ball animation: owns the ball centre coordinates and produces the h_pos/v_pos consumed by the frame painter.
- Advances the ball once per frame, reflects it off the screen edges (keeping the whole ball visible) and publishes the new centre only at frame boundaries, so the painter never sees a torn frame.
- Sits between the XGA timing generator (frame_start) and the ball renderer (h_pos, v_pos).

---
 rtl/ball_motion_pkg.sv | 23 ++
 rtl/ball_motion_axis_bounce.sv | 30 +++
 rtl/ball_motion.sv | 108 ++++++++++
 tb/tb_ball_motion.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ball_motion_pkg.sv
// ball_motion_pkg: shared FSM encoding, direction constants and the log2 helper
// used by ball_motion and its axis_bounce sub-module.
package ball_motion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    // ceil(log2(v)): bits needed to hold 0..v-1
    function automatic int log2(input int v);
        int n;
        n = 0;
        while ((1 << n) < v) n++;
        return n;
    endfunction

endpackage

// File: rtl/ball_motion_axis_bounce.sv
// ball_motion_axis_bounce: combinational step-and-reflect for one axis; moves pos
// by step in direction dir and clamps to [lo, hi], flipping dir on a clamp.
module ball_motion_axis_bounce
    import ball_motion_pkg::*;
#(
    parameter int aw = 12
) (
    input  logic signed [aw-1:0] pos,
    input  logic                 dir,
    input  logic signed [aw-1:0] step,
    input  logic signed [aw-1:0] lo,
    input  logic signed [aw-1:0] hi,
    output logic signed [aw-1:0] next_pos,
    output logic                 next_dir,
    output logic                 flipped
);

    logic signed [aw-1:0] sum;
    logic over, under;

    always_comb begin
        sum      = dir == DIR_NEG ? pos - step : pos + step;
        over     = sum > hi;
        under    = sum < lo;
        next_pos = over ? hi : under ? lo : sum;
        flipped  = over || under;
        next_dir = dir ^ flipped;
    end

endmodule

// File: rtl/ball_motion.sv
// ball_motion: per-frame ball centre generator with edge reflection; publishes
// h_pos/v_pos only on pos_valid. Define BALL_BOUNCE_CNT_EN to add bounce_cnt.
module ball_motion
    import ball_motion_pkg::*;
#(
    parameter int width       = 1024,
    parameter int height      = 768,
    parameter int ball_radius = 16,
    parameter int step_x      = 2,
    parameter int step_y      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      move,
    output logic [log2(width)-1:0]    h_pos,
    output logic [log2(height)-1:0]   v_pos,
    output logic                      dir_x,
    output logic                      dir_y,
    output logic                      pos_valid,
    output logic                      bounce,
    output logic                      busy
`ifdef BALL_BOUNCE_CNT_EN
    ,
    output logic [15:0]               bounce_cnt
`endif
);

    localparam int xw = log2(width);
    localparam int yw = log2(height);
    localparam int pw = xw > yw ? xw : yw;
    localparam int aw = pw + 2;

    state_t state, next;
    logic [xw-1:0] shadow_x;
    logic [yw-1:0] shadow_y;
    logic ndx, flip_any;
    logic sel_y;
    logic signed [aw-1:0] a_pos, a_step, a_hi, a_next;
    logic a_dir, a_ndir, a_flip;
    logic unused_hi;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state == IDLE   ? (frame_start && move ? CALC_X : IDLE) :
               state == CALC_X ? CALC_Y :
               state == CALC_Y ? COMMIT : IDLE;
        busy      = state == CALC_X || state == CALC_Y;
        pos_valid = state == COMMIT;
        bounce    = state == COMMIT && flip_any;
    end

    // one reflect unit, time-shared between the two axes
    always_comb begin
        sel_y  = state == CALC_Y;
        a_pos  = sel_y ? aw'(shadow_y) : aw'(shadow_x);
        a_step = sel_y ? aw'(step_y) : aw'(step_x);
        a_hi   = sel_y ? aw'(height - 1 - ball_radius) : aw'(width - 1 - ball_radius);
        a_dir  = sel_y ? dir_y : dir_x;
    end

    ball_motion_axis_bounce #(.aw(aw)) u_axis (
        .pos      (a_pos),
        .dir      (a_dir),
        .step     (a_step),
        .lo       (aw'(ball_radius)),
        .hi       (a_hi),
        .next_pos (a_next),
        .next_dir (a_ndir),
        .flipped  (a_flip)
    );

    assign unused_hi = ^a_next[aw-1:pw];

    // published registers load on the CALC_Y edge so they are already new while pos_valid is high
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            shadow_x <= xw'(width / 2);
            shadow_y <= yw'(height / 2);
            h_pos    <= xw'(width / 2);
            v_pos    <= yw'(height / 2);
            dir_x    <= DIR_POS;
            dir_y    <= DIR_POS;
            ndx      <= DIR_POS;
            flip_any <= 1'b0;
        end else if (state == CALC_X) begin
            shadow_x <= a_next[xw-1:0];
            ndx      <= a_ndir;
            flip_any <= a_flip;
        end else if (state == CALC_Y) begin
            shadow_y <= a_next[yw-1:0];
            h_pos    <= shadow_x;
            v_pos    <= a_next[yw-1:0];
            dir_x    <= ndx;
            dir_y    <= a_ndir;
            flip_any <= flip_any || a_flip;
        end

`ifdef BALL_BOUNCE_CNT_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) bounce_cnt <= '0;
        else if (bounce && bounce_cnt != 16'hFFFF) bounce_cnt <= bounce_cnt + 16'd1;
`endif

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: scoreboard bench for ball_motion; expected positions are queued
// when a frame is launched and compared when pos_valid appears.
module tb_ball_motion;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame_start = 1'b0;
    logic move = 1'b0;
    logic [9:0] h_pos, v_pos;
    logic dir_x, dir_y, pos_valid, bounce, busy;
`ifdef BALL_BOUNCE_CNT_EN
    logic [15:0] bounce_cnt;
`endif

    always #5 clk = ~clk;

    ball_motion dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .move        (move),
        .h_pos       (h_pos),
        .v_pos       (v_pos),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .pos_valid   (pos_valid),
        .bounce      (bounce),
        .busy        (busy)
`ifdef BALL_BOUNCE_CNT_EN
        ,
        .bounce_cnt  (bounce_cnt)
`endif
    );

    typedef struct {
        int h;
        int v;
        bit dx;
        bit dy;
        bit b;
    } exp_t;

    exp_t q[$];
    exp_t got_e;
    int checks = 0;
    int errors = 0;
    int mx = 512, my = 384;
    bit mdx = 1'b0, mdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_axis(inout int p, inout bit d, input int s, input int lo, input int hi, inout bit f);
        p = d ? p - s : p + s;
        if (p > hi) begin p = hi; d = ~d; f = 1'b1; end
        else if (p < lo) begin p = lo; d = ~d; f = 1'b1; end
    endtask

    task automatic push_expected();
        bit f;
        exp_t e;
        f = 1'b0;
        model_axis(mx, mdx, 2, 16, 1007, f);
        model_axis(my, mdy, 2, 16, 751, f);
        e = '{mx, my, mdx, mdy, f};
        q.push_back(e);
    endtask

    task automatic frame(input bit expect_update);
        @(negedge clk);
        frame_start = 1'b1;
        if (expect_update) push_expected();
        @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk)
        if (reset) begin
            if (pos_valid) begin
                if (q.size() == 0) check("spurious_pos_valid", 1, 0);
                else begin
                    got_e = q.pop_front();
                    check("h_pos", 32'(h_pos), got_e.h);
                    check("v_pos", 32'(v_pos), got_e.v);
                    check("dir_x", 32'(dir_x), 32'(got_e.dx));
                    check("dir_y", 32'(dir_y), 32'(got_e.dy));
                    check("bounce", 32'(bounce), 32'(got_e.b));
                end
            end else if (bounce) check("bounce_without_pos_valid", 1, 0);
        end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_h", 32'(h_pos), 512);
        check("rst_v", 32'(v_pos), 384);
        check("rst_dir", {dir_x, dir_y}, 0);
        check("rst_pv", 32'(pos_valid), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef BALL_BOUNCE_CNT_EN
        check("rst_cnt", 32'(bounce_cnt), 0);
`endif
        move = 1'b1;
        // frame 1: cycle-accurate latency
        @(negedge clk);
        frame_start = 1'b1;
        push_expected();
        @(negedge clk);
        frame_start = 1'b0;
        check("lat_busy1", 32'(busy), 1);
        check("lat_pv1", 32'(pos_valid), 0);
        @(negedge clk);
        check("lat_busy2", 32'(busy), 1);
        check("lat_pv2", 32'(pos_valid), 0);
        @(negedge clk);
        check("lat_pv3", 32'(pos_valid), 1);
        check("lat_busy3", 32'(busy), 0);
        check("lat_h3", 32'(h_pos), 514);
        check("lat_v3", 32'(v_pos), 386);
        @(negedge clk);
        check("lat_pv4", 32'(pos_valid), 0);
        repeat (2) @(negedge clk);
        for (int i = 2; i <= 248; i++) begin
            frame(1'b1);
            if (i == 184) begin
                check("f184_v", 32'(v_pos), 751);
                check("f184_dir_y", 32'(dir_y), 1);
            end
            if (i == 185) check("f185_v", 32'(v_pos), 749);
            if (i == 248) begin
                check("f248_h", 32'(h_pos), 1007);
                check("f248_dir_x", 32'(dir_x), 1);
`ifdef BALL_BOUNCE_CNT_EN
                check("f248_cnt", 32'(bounce_cnt), 2);
`endif
            end
        end
        // back-to-back frame_start, move dropped mid-update
        @(negedge clk);
        frame_start = 1'b1;
        push_expected();
        @(negedge clk);
        move = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) frame(1'b0);
        check("idle_h", 32'(h_pos), mx);
        check("idle_v", 32'(v_pos), my);
        // reset asserted while in CALC_Y
        move = 1'b1;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("midrst_h", 32'(h_pos), 512);
        check("midrst_v", 32'(v_pos), 384);
        check("midrst_dir", {dir_x, dir_y}, 0);
        check("midrst_busy0", 32'(busy), 0);
`ifdef BALL_BOUNCE_CNT_EN
        check("midrst_cnt", 32'(bounce_cnt), 0);
`endif
        mx = 512;
        my = 384;
        mdx = 1'b0;
        mdy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_h", 32'(h_pos), 512);
        check("pending_updates", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
